// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle: pixel-rate strobe in, scan position, syncs and frame markers out.
// The generator drives the timing outputs through the master modport; renderers consume them through slave.
interface vga_timing_gen_if;
    logic       pixel_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        input  pixel_en,
        output x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pixel_en,
        input  x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster scan generator: h/v counters plus registered x/y, syncs, display-enable and frame markers.
// Every output is derived from the next (h,v), so all of them line up on the same clock edge.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input logic             clk,
    input logic             reset,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so a window ending exactly at 1024 stays representable.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON  = SYNC_POL;
    localparam logic        SYNC_OFF = ~SYNC_POL;

    function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    logic [9:0] h_p0, v_p0;
    logic [9:0] h_nxt, v_nxt;
    logic       wrap_h, wrap_v;
    logic       de_p0, hsync_p0, vsync_p0;
    logic       line_start_p0, frame_start_p0;
    logic [7:0] frame_cnt_p0;

    always_comb begin
        h_nxt  = h_p0;
        v_nxt  = v_p0;
        wrap_h = 1'b0;
        wrap_v = 1'b0;
        if (vif.pixel_en) begin
            if (h_p0 == H_LAST) begin
                h_nxt  = 10'd0;
                wrap_h = 1'b1;
                if (v_p0 == V_LAST) begin
                    v_nxt  = 10'd0;
                    wrap_v = 1'b1;
                end else begin
                    v_nxt = v_p0 + 10'd1;
                end
            end else begin
                h_nxt = h_p0 + 10'd1;
            end
        end
    end

    // Stage p0: counters and every output registered from the next position.
    // With pixel_en low the next position equals the current one, so levels hold
    // while the wrap pulses, which only fire on an advance, drop after one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_p0           <= H_LAST;
            v_p0           <= V_LAST;
            de_p0          <= 1'b0;
            hsync_p0       <= SYNC_OFF;
            vsync_p0       <= SYNC_OFF;
            line_start_p0  <= 1'b0;
            frame_start_p0 <= 1'b0;
            frame_cnt_p0   <= 8'd0;
        end else begin
            h_p0           <= h_nxt;
            v_p0           <= v_nxt;
            de_p0          <= in_window(h_nxt, 11'd0, H_ACT) && in_window(v_nxt, 11'd0, V_ACT);
            hsync_p0       <= in_window(h_nxt, HS_BEG, HS_END) ? SYNC_ON : SYNC_OFF;
            vsync_p0       <= in_window(v_nxt, VS_BEG, VS_END) ? SYNC_ON : SYNC_OFF;
            line_start_p0  <= wrap_h;
            frame_start_p0 <= wrap_v;
            frame_cnt_p0   <= frame_cnt_p0 + 8'(wrap_v);
        end
    end

    assign vif.x           = h_p0;
    assign vif.y           = v_p0;
    assign vif.de          = de_p0;
    assign vif.hsync       = hsync_p0;
    assign vif.vsync       = vsync_p0;
    assign vif.line_start  = line_start_p0;
    assign vif.frame_start = frame_start_p0;
    assign vif.frame_cnt   = frame_cnt_p0;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan for the HDMI/VGA output path: pixel coordinates x/y, hsync, vsync and display-enable.
- Its x, y and vsync outputs drive every sprite renderer and the background layer.
- Sprite renderers latch their positions on the vsync falling edge, so that edge must fall inside vertical blanking.
- Defaults are 640x480@60 (800x525 total), advancing one pixel per clock cycle in which pixel_en is high.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pixel_en  in  1  pixel-rate strobe; counters advance only on cycles where it is 1
- x  out  10  horizontal position, 0..H_TOTAL-1
- y  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level set by SYNC_POL
- vsync  out  1  vertical sync, level set by SYNC_POL
- de  out  1  display enable; 1 only inside the active area
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
- frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is the vertical equivalent.
- Both totals must be <=1024; elaboration errors out otherwise.
- Internal state: 10-bit h and v counters.
- All outputs are registered and always reflect the current (h,v); there is no pipeline skew between x, y, de and the syncs.
- Reset values (asynchronous, while reset=0):
  - h = x = H_TOTAL-1; v = y = V_TOTAL-1
  - de = 0; hsync = vsync = ~SYNC_POL
  - line_start = frame_start = 0; frame_cnt = 0
- The reset position is the last pixel of the last line. The first pixel_en after reset release therefore lands on (0,0) with de=1 and frame_start=1, and frame_cnt becomes 1.
- Advance rule on a clk edge with pixel_en=1:
  - if h == H_TOTAL-1: h <= 0, and v <= (v == V_TOTAL-1) ? 0 : v+1
  - else: h <= h+1
- pixel_en=0: h, v, x, y, de, hsync, vsync and frame_cnt all hold their values.
- de = (h < H_ACTIVE) && (v < V_ACTIVE), evaluated on the new (h,v).
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; ~SYNC_POL otherwise.
- vsync = SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; ~SYNC_POL otherwise.
  - vsync depends only on v, so it changes at h=0 of the boundary lines.
- line_start: 1 for exactly the clk after an advance that set h to 0.
- frame_start: 1 for exactly the clk after an advance that set (h,v) to (0,0).
- Both pulses clear on the next clk edge regardless of pixel_en. They never last more than one clk, even when pixel_en is held high.
- frame_cnt increments (mod 256) on the same edge that raises frame_start.
- Simultaneous line and frame wrap: both pulses assert together.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Counting resumes from the reset position after release.

Test Plan:
- Reset release, pixel_en=1 constantly → 1st edge: x=0, y=0, de=1, frame_start=1, line_start=1, frame_cnt=1. 2nd edge: both pulses 0, x=1.
- Free-run one line → de falls when x becomes 640. hsync=0 for x=656..751, 1 at x=752. x wraps 799→0, y 0→1, line_start=1 for one clk.
- Free-run a full frame → de=0 for all y>=480. vsync=0 only for y=490..491 (falls at x=0,y=490; rises at x=0,y=492). At x=0,y=0 after y=524: frame_start=1, frame_cnt=2. Total edges per frame = 420000.
- pixel_en toggling 1,0,1,0 (divide-by-2) → x advances every other clk. frame_start and line_start each stay high exactly one clk. Frame length = 840000 clks.
- Assert reset at x=300,y=200 → outputs immediately become x=799, y=524, de=0, hsync=vsync=1, frame_cnt=0. Restart begins with a frame_start.
- frame_cnt wrap → after 256 frames frame_cnt reads 0. frame_start still pulses.
